// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the memory-copy DMA: FSM state encoding,
// default widths and the RAM depth.
package mem_copy_dma_pkg;

    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 16;
    localparam int LW_DEF    = 9;
    localparam int RAM_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } dma_state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Word-by-word RAM-to-RAM copier: alternates one READ cycle and one WRITE
// cycle per word, then pulses done for a single FIN cycle.
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [LW-1:0] len,
    output logic [AW-1:0] ram_address,
    output logic          ram_load,
    output logic [DW-1:0] ram_inp,
    input  logic [DW-1:0] ram_outp,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] count
);

    dma_state_e    state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] data_q, data_d;
    logic [LW-1:0] count_q, count_d;

    logic [LW-1:0] cnt_inc;
    logic          last_word;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;

    // Address adders wrap naturally modulo 2^AW.
    assign cnt_inc   = count_q + LW'(1);
    assign last_word = (cnt_inc == len_q);
    assign rd_addr   = src_q + AW'(count_q);
    assign wr_addr   = dst_q + AW'(count_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_FIN : ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? ST_FIN : ST_READ;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode purely from state so an asynchronous reset drops
    // ram_load before the next edge.
    always_comb begin
        ram_address = '0;
        ram_load    = 1'b0;
        ram_inp     = '0;
        done        = 1'b0;
        busy        = (state_q != ST_IDLE);
        case (state_q)
            ST_READ: begin
                ram_address = rd_addr;
            end
            ST_WRITE: begin
                ram_address = wr_addr;
                ram_load    = 1'b1;
                ram_inp     = data_q;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src;
                    dst_d   = dst;
                    len_d   = len;
                    count_d = '0;
                end
            end
            ST_READ:  data_d  = ram_outp;
            ST_WRITE: count_d = cnt_inc;
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma with a behavioural RAM and a
// write scoreboard fed from a reference copy model.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] dst = '0;
    logic [8:0]  len = '0;
    logic [15:0] ram_address;
    logic        ram_load;
    logic [15:0] ram_inp;
    logic [15:0] ram_outp;
    logic        busy;
    logic        done;
    logic [8:0]  count;

    logic        init_req  = 1'b0;
    logic        poke_en   = 1'b0;
    logic [15:0] poke_addr = '0;
    logic [15:0] poke_data = '0;

    logic [15:0] mem   [0:65535];
    logic [15:0] model [0:65535];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;
    wr_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    mem_copy_dma dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .ram_address(ram_address),
        .ram_load   (ram_load),
        .ram_inp    (ram_inp),
        .ram_outp   (ram_outp),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    assign ram_outp = mem[ram_address];

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'hA000 + 16'(i);
        end else if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (ram_load) begin
            mem[ram_address] <= ram_inp;
        end
    end

    task automatic push_exp(input logic [15:0] s, input logic [15:0] d, input int n);
        logic [15:0] a;
        logic [15:0] v;
        for (int k = 0; k < n; k++) begin
            a = s + 16'(k);
            v = model[a];
            model[d + 16'(k)] = v;
            exp_q.push_back('{a: d + 16'(k), d: v});
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = v;
        model[a] = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Runs one transfer from the start edge, checking every cycle.
    task automatic run_xfer(input string name, input logic [15:0] s, input logic [15:0] d,
                            input int n, input int restart_c, input int abort_c,
                            output int done_c, output int n_done);
        logic [33:0] got, expv;
        logic [15:0] ea;
        logic [59:0] zgot;
        wr_t         w;
        bit          aborted;
        int          k;
        aborted = 1'b0;
        done_c  = -1;
        n_done  = 0;
        @(negedge clk);
        src = s; dst = d; len = 9'(n); start = 1'b1;
        for (int c = 1; c <= 2 * n + 4; c++) begin
            @(posedge clk);
            if (c == abort_c) begin
                #2;
                reset = 1'b1;
                #1;
            end
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == abort_c) begin
                zgot = {busy, done, ram_load, ram_address, ram_inp, count, 16'h0};
                checks++;
                if (zgot !== 60'h0) begin
                    failures++;
                    $display("FAIL %s abort outputs: got %h want 0", name, zgot);
                end
                aborted = 1'b1;
                break;
            end
            got = {busy, ram_load, ram_address, (ram_load ? 16'h0 : ram_inp)};
            if (c <= 2 * n) begin
                k  = (c - 1) / 2;
                ea = (c % 2 == 1) ? s + 16'(k) : d + 16'(k);
                expv = {1'b1, (c % 2 == 0), ea, 16'h0};
            end else if (c == 2 * n + 1) begin
                expv = {1'b1, 1'b0, 16'h0, 16'h0};
            end else begin
                expv = '0;
            end
            checks++;
            if (got !== expv) begin
                failures++;
                $display("FAIL %s cycle %0d busy/load/addr/inp: got %h want %h", name, c, got, expv);
            end
            if (ram_load) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected write cycle %0d: got %h:%h want none", name, c, ram_address, ram_inp);
                end else begin
                    w = exp_q.pop_front();
                    if ({ram_address, ram_inp} !== {w.a, w.d}) begin
                        failures++;
                        $display("FAIL %s write data cycle %0d: got %h:%h want %h:%h",
                                 name, c, ram_address, ram_inp, w.a, w.d);
                    end
                end
            end
            if (done) begin
                n_done++;
                if (done_c < 0) done_c = c;
            end
            if (c == restart_c) begin
                src = s + 16'h0100; dst = d + 16'h0100; len = 9'd7; start = 1'b1;
            end
            if (c == restart_c + 1) start = 1'b0;
        end
        if (aborted) begin
            @(posedge clk);
            @(negedge clk);
            if (done) n_done++;
            reset = 1'b0;
        end else begin
            checks++;
            if (count !== 9'(n)) begin
                failures++;
                $display("FAIL %s final count: got %0d want %0d", name, count, n);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending writes: got %0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 65536; i++) model[i] = 16'hA000 + 16'(i);
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, ram_load, ram_address, ram_inp, count} !== 44'h0) begin
            failures++;
            $display("FAIL reset outputs: got %h want 0",
                     {busy, done, ram_load, ram_address, ram_inp, count});
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int dc, nd;
        push_exp(16'h0010, 16'h0080, 4);
        run_xfer("basic", 16'h0010, 16'h0080, 4, 0, 0, dc, nd);
        checks++;
        if (dc !== 9 || nd !== 1) begin
            failures++;
            $display("FAIL basic done: got cycle %0d pulses %0d want cycle 9 pulses 1", dc, nd);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[16'h0080 + 16'(k)] !== 16'hA010 + 16'(k)) begin
                failures++;
                $display("FAIL basic mem[%h]: got %h want %h", 16'h0080 + 16'(k),
                         mem[16'h0080 + 16'(k)], 16'hA010 + 16'(k));
            end
        end
    endtask

    task automatic test_len_zero();
        int dc, nd;
        run_xfer("len0", 16'h0010, 16'h00C0, 0, 0, 0, dc, nd);
        checks++;
        if (dc !== 1 || nd !== 1 || mem[16'h00C0] !== 16'hA0C0) begin
            failures++;
            $display("FAIL len0: got cycle %0d pulses %0d mem %h want cycle 1 pulses 1 mem a0c0",
                     dc, nd, mem[16'h00C0]);
        end
    endtask

    task automatic test_wrap();
        int dc, nd;
        logic [15:0] want [3];
        want[0] = 16'h9FFE; want[1] = 16'h9FFF; want[2] = 16'hA000;
        push_exp(16'hFFFE, 16'h0040, 3);
        run_xfer("wrap", 16'hFFFE, 16'h0040, 3, 0, 0, dc, nd);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (mem[16'h0040 + 16'(k)] !== want[k]) begin
                failures++;
                $display("FAIL wrap mem[%h]: got %h want %h", 16'h0040 + 16'(k),
                         mem[16'h0040 + 16'(k)], want[k]);
            end
        end
    endtask

    task automatic test_restart_ignored();
        int dc, nd;
        push_exp(16'h0050, 16'h00A0, 3);
        run_xfer("restart", 16'h0050, 16'h00A0, 3, 3, 0, dc, nd);
        checks++;
        if (dc !== 7 || nd !== 1) begin
            failures++;
            $display("FAIL restart done: got cycle %0d pulses %0d want cycle 7 pulses 1", dc, nd);
        end
        checks++;
        if (mem[16'h01A0] !== 16'hA1A0) begin
            failures++;
            $display("FAIL restart stray write: got %h want a1a0", mem[16'h01A0]);
        end
    endtask

    task automatic test_overlap();
        int dc, nd;
        poke(16'h0020, 16'h1111);
        push_exp(16'h0020, 16'h0021, 3);
        run_xfer("overlap", 16'h0020, 16'h0021, 3, 0, 0, dc, nd);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (mem[16'h0020 + 16'(k)] !== 16'h1111) begin
                failures++;
                $display("FAIL overlap mem[%h]: got %h want 1111", 16'h0020 + 16'(k),
                         mem[16'h0020 + 16'(k)]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int dc, nd;
        push_exp(16'h0030, 16'h0090, 2);
        run_xfer("abort", 16'h0030, 16'h0090, 4, 0, 6, dc, nd);
        checks++;
        if ({mem[16'h0090], mem[16'h0091], mem[16'h0092]} !== {16'hA030, 16'hA031, 16'hA092} || nd !== 0) begin
            failures++;
            $display("FAIL abort mem/done: got %h %h %h pulses %0d want a030 a031 a092 pulses 0",
                     mem[16'h0090], mem[16'h0091], mem[16'h0092], nd);
        end
    endtask

    task automatic test_back_to_back();
        int dc, nd;
        push_exp(16'h0100, 16'h0200, 2);
        run_xfer("b2b_a", 16'h0100, 16'h0200, 2, 0, 0, dc, nd);
        checks++;
        if (dc !== 5 || nd !== 1) begin
            failures++;
            $display("FAIL b2b_a done: got cycle %0d pulses %0d want cycle 5 pulses 1", dc, nd);
        end
        push_exp(16'h0200, 16'h0300, 1);
        run_xfer("b2b_b", 16'h0200, 16'h0300, 1, 0, 0, dc, nd);
        checks++;
        if (dc !== 3 || nd !== 1 || mem[16'h0300] !== 16'hA100) begin
            failures++;
            $display("FAIL b2b_b: got cycle %0d pulses %0d mem %h want cycle 3 pulses 1 mem a100",
                     dc, nd, mem[16'h0300]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_restart_ignored();
        test_overlap();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter: DW, 16, data word width (matches RAM word).
REQ-002 Parameter: AW, 16, RAM address width.
REQ-003 Parameter: LW, 9, transfer-length width (0..256 words).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request a copy; sampled on rising clk.
REQ-007 src  input  AW  source start address; sampled with start.
REQ-008 dst  input  AW  destination start address; sampled with start.
REQ-009 len  input  LW  word count; sampled with start.
REQ-010 ram_address  output  AW  address to RAM.
REQ-011 ram_load  output  1  RAM write enable; RAM writes on the next rising clk.
REQ-012 ram_inp  output  DW  write data to RAM.
REQ-013 ram_outp  input  DW  RAM combinational read data for ram_address.
REQ-014 busy  output  1  high while a transfer is in progress.
REQ-015 done  output  1  one-cycle pulse at end of every accepted transfer.
REQ-016 count  output  LW  words written so far in the current or last transfer.

Function
REQ-017 States SHALL be IDLE, READ, WRITE, FIN; the encoding is shared (REQ-033).
REQ-018 IDLE: start=1 at an edge SHALL latch src, dst and len, clear count, and enter READ, or FIN if len=0.
REQ-019 READ: ram_address SHALL equal src+count and ram_load=0; the next edge SHALL capture ram_outp into the data register and enter WRITE.
REQ-020 WRITE: ram_address SHALL equal dst+count, ram_load=1 and ram_inp=data register; the next edge SHALL increment count and enter READ, or FIN if count+1=len.
REQ-021 FIN: done SHALL be 1 for exactly this one cycle; the next edge SHALL return to IDLE.
REQ-022 busy SHALL be 1 in READ, WRITE and FIN, and 0 in IDLE.
REQ-023 Timing: with start at edge E0 and len=N>0, word k SHALL be read in cycle 2k+1 and written in cycle 2k+2, and done SHALL be high in cycle 2N+1.
REQ-024 start while busy=1 SHALL be ignored, with no queuing.
REQ-025 Address arithmetic SHALL be modulo 2^AW; 16'hFFFF+1 wraps to 0.
REQ-026 Overlapping regions SHALL be copied forward, word by word, in ascending order; no hazard correction.
REQ-027 ram_load SHALL be 0 in every state except WRITE.
REQ-028 In IDLE and FIN, ram_address and ram_inp SHALL be 0.
REQ-029 count SHALL hold its final value after FIN until the next accepted start.

Reset
REQ-030 While reset=1, the block SHALL be in IDLE immediately (asynchronously), with all outputs 0 and the latched src, dst, len and data registers at 0.
REQ-031 Reset asserted in WRITE SHALL drop ram_load before the next edge, so no RAM write occurs; the transfer is aborted and no done pulse is produced.
REQ-032 After reset deasserts, the first edge SHALL accept start normally.

Structure
REQ-033 The state enum, DW/AW/LW defaults and the RAM depth constant (256) SHALL reside in the shared processor package.
REQ-034 No sub-module: the FSM, count register, data register and two address adders SHALL live in mem_copy_dma.

Verification
REQ-035 Test: RAM preloaded with mem[i]=16'hA000+i; start with src=0x10, dst=0x80, len=4 -> mem[0x80..0x83]=A010..A013, done in cycle 9, count=4.
REQ-036 Test: len=0 -> busy=1 for one cycle, done pulses in cycle 1, ram_load never asserted, RAM unchanged.
REQ-037 Test: src=0xFFFE, len=3 -> reads from FFFE, FFFF, 0000 (wrap), writes to dst..dst+2.
REQ-038 Test: start pulsed again mid-transfer with different src -> ignored, first transfer completes unchanged, exactly one done pulse.
REQ-039 Test: reset asserted during the WRITE of word 2 of len=4 -> ram_load falls at once, mem[dst+2] unchanged, busy=0, done never pulses.
REQ-040 Test: overlap src=0x20, dst=0x21, len=3 with mem[0x20]=1111 -> mem[0x21..0x23]=1111 (forward replication).
